// File: rtl/cla_nibble_seq.sv
// Nibble-serial adder/subtractor. It pushes one shared 4-bit carry-lookahead
// slice across the operands, least significant nibble first. The result is
// held in registers behind a valid/ready handshake.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. The
// requester must hold its request until it transfers, and the result stays
// stable until it transfers. in_ready is high only in IDLE, so requests are
// never accepted while a result is pending.
module cla_nibble_seq #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_r;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [4:0]       c;
  logic [3:0]       slice_s;
  logic [WIDTH-1:0] sum_next;
  logic             last_pass;

  // The operands shift right each pass, so the slice always reads the low nibble.
  // It uses fully expanded lookahead carries.
  always_comb begin
    nib_a   = op_a[3:0];
    nib_b   = op_b[3:0];
    g       = nib_a & nib_b;
    p       = nib_a ^ nib_b;
    c[0]    = carry;
    c[1]    = g[0] | (p[0] & c[0]);
    c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c[0]);
    slice_s = p ^ c[3:0];
  end

  // Assemble the sum with this pass's nibble merged in. The final-edge flags
  // (zero and the sign of the result) are taken from this merged value.
  always_comb begin
    sum_next = sum_r;
    sum_next[4 * int'(cnt) +: 4] = slice_s;
    last_pass = (cnt == CW'(NIBBLES - 1));
  end

  // Sequencer FSM, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a       <= a;
            op_b       <= sub ? ~b : b;
            carry      <= sub ? 1'b1 : cin;
            cnt        <= '0;
            sign_a     <= a[WIDTH-1];
            sign_b     <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            state      <= RUN;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b0;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= c[4];
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          if (last_pass) begin
            cout_r      <= c[4];
            ovf_r       <= (sign_a == sign_b) && (sum_next[WIDTH-1] != sign_a);
            zero_r      <= (sum_next == '0);
            state       <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq with WIDTH=16.
module tb_cla_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cla_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for out_valid. lat counts edges from the accept edge (inclusive).
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                       input logic vs, output int lat);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL issue_timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [15:0] es, input logic ec,
                              input logic eo, input logic ez);
    checks++;
    if ({sum, cout, ovf, zero} !== {es, ec, eo, ez}) begin
      errors++;
      $display("FAIL %s: sum=%h cout=%b ovf=%b zero=%b, required sum=%h cout=%b ovf=%b zero=%b",
               name, sum, cout, ovf, zero, es, ec, eo, ez);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hs: in_ready/out_valid/busy=%b, required 100", {in_ready, out_valid, busy});
    end
    check_result("reset_regs", 16'h0000, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int lat;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL add_latency: %0d edges, required 5", lat);
    end
    check_result("add_ffff_1", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_result();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    check_result("add_7fff_1", 16'h8000, 1'b0, 1'b1, 1'b0);
    release_result();
    issue(16'h00FF, 16'h0000, 1'b1, 1'b0, lat);
    check_result("add_00ff_cin", 16'h0100, 1'b0, 1'b0, 1'b0);
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    issue(16'h1234, 16'h1235, 1'b0, 1'b1, lat);
    check_result("sub_borrow", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    release_result();
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
    check_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    release_result();
    issue(16'h5A5A, 16'h5A5A, 1'b0, 1'b1, lat);
    check_result("sub_equal", 16'h0000, 1'b1, 1'b0, 1'b1);
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h4000, 16'h4000, 1'b0, 1'b0, lat);
    a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b100) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid/in_ready/busy=%b, required 100", i, {out_valid, in_ready, busy});
      end
      check_result("bp_stable", 16'h8000, 1'b0, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: out_valid/in_ready/busy=%b, required 010", {out_valid, in_ready, busy});
    end
    check_result("bp_after_idle", 16'h8000, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_input_change();
    int lat;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      a = a - 16'h1111;
    end
    check_result("input_change", 16'h1010, 1'b0, 1'b0, 1'b0);
    release_result();
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int n_done = 0;
    a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (in_ready) acc.push_back(e);
      if (out_valid && n_done < 2) begin
        n_done++;
        check_result("b2b_result", 16'h0007, 1'b0, 1'b0, 1'b0);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (acc.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: %0d accepts, required >= 3", acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
        errors++;
        $display("FAIL b2b_spacing: %0d and %0d cycles, required 6", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    checks++;
    if (n_done !== 2) begin
      errors++;
      $display("FAIL b2b_results: %0d results seen, required 2", n_done);
    end
    for (int i = 0; i < 10 && !in_ready; i++) begin
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_mid: out_valid/busy/in_ready=%b, required 001", {out_valid, busy, in_ready});
    end
    check_result("rst_mid_regs", 16'h0000, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_release: out_valid/in_ready=%b, required 01", {out_valid, in_ready});
    end
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    check_result("post_rst_add", 16'h3333, 1'b0, 1'b0, 1'b0);
    release_result();
  endtask

  // Test sequence and summary.
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_input_change();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
